// File: rtl/dp_seq_ctrl.sv
// dp_seq_ctrl: Moore sequencer that walks A-element pairs through load/compare
// and writes one B entry per pair, with a registered add/sub select.
module dp_seq_ctrl #(
  parameter int PAIRS = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic sign,
  output logic resetA,
  output logic incA,
  output logic resetB,
  output logic incB,
  output logic ld_reg,
  output logic sel,
  output logic we_b,
  output logic busy,
  output logic done
);
  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] CLR   = 3'd1;
  localparam logic [2:0] LOADA = 3'd2;
  localparam logic [2:0] CMP   = 3'd3;
  localparam logic [2:0] WRB   = 3'd4;
  localparam logic [2:0] DONE  = 3'd5;
  logic [2:0] state, state_nxt;
  logic [1:0] pcnt;
  logic       sel_r;
  logic       last;
  assign last = pcnt == 2'(PAIRS - 1);
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      pcnt  <= '0;
      sel_r <= 1'b0;
    end else begin
      state <= state_nxt;
      pcnt  <= state == CLR ? 2'd0 : (state == WRB && !last) ? pcnt + 2'd1 : pcnt;
      sel_r <= state == CMP ? sign : state == DONE ? 1'b0 : sel_r;
    end
  end
  always_comb begin
    state_nxt = IDLE;
    case (state)
      IDLE:    state_nxt = start ? CLR : IDLE;
      CLR:     state_nxt = LOADA;
      LOADA:   state_nxt = CMP;
      CMP:     state_nxt = WRB;
      WRB:     state_nxt = last ? DONE : LOADA;
      default: state_nxt = IDLE;
    endcase
  end
  // sel is only presented while the captured compare result is being used
  always_comb begin
    resetA = state == CLR;
    resetB = state == CLR;
    incA   = state == LOADA || state == CMP;
    ld_reg = state == LOADA;
    incB   = state == WRB;
    we_b   = state == WRB;
    sel    = state == WRB ? sel_r : 1'b0;
    busy   = state == CLR || state == LOADA || state == CMP || state == WRB || state == DONE;
    done   = state == DONE;
  end
endmodule

// File: tb/tb_dp_seq_ctrl.sv
// tb_dp_seq_ctrl: scoreboard bench running PAIRS=4 and PAIRS=1 instances side by side.
module tb_dp_seq_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic start = 1'b0;
  logic sign = 1'b0;
  logic [8:0] o [2];
  logic ra4, ia4, rb4, ib4, ld4, sl4, we4, bs4, dn4;
  logic ra1, ia1, rb1, ib1, ld1, sl1, we1, bs1, dn1;
  int checks = 0;
  int errors = 0;
  logic [8:0] q [2][$];
  int pp [2] = '{4, 1};
  int mt [2] = '{-1, -1};
  bit ms [2] = '{0, 0};
  int rc [2] = '{0, 0};
  int na [2] = '{0, 0};
  int nb [2] = '{0, 0};
  int nw [2] = '{0, 0};
  always #5 clk = ~clk;
  dp_seq_ctrl #(.PAIRS(4)) dut4 (
    .clk(clk), .reset(reset), .start(start), .sign(sign),
    .resetA(ra4), .incA(ia4), .resetB(rb4), .incB(ib4), .ld_reg(ld4),
    .sel(sl4), .we_b(we4), .busy(bs4), .done(dn4)
  );
  dp_seq_ctrl #(.PAIRS(1)) dut1 (
    .clk(clk), .reset(reset), .start(start), .sign(sign),
    .resetA(ra1), .incA(ia1), .resetB(rb1), .incB(ib1), .ld_reg(ld1),
    .sel(sl1), .we_b(we1), .busy(bs1), .done(dn1)
  );
  assign o[0] = {ra4, ia4, rb4, ib4, ld4, sl4, we4, bs4, dn4};
  assign o[1] = {ra1, ia1, rb1, ib1, ld1, sl1, we1, bs1, dn1};
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  // bits: resetA incA resetB incB ld_reg sel we_b busy done; t = cycles since CLR, -1 = idle
  function automatic logic [8:0] mexp(input int t, input int p, input bit s);
    if (t < 0) return 9'b000000000;
    if (t == 0) return 9'b101000010;
    if (t == 3 * p + 1) return 9'b000000011;
    case ((t - 1) % 3)
      0: return 9'b010010010;
      1: return 9'b010000010;
      default: return {5'b00010, s, 3'b110};
    endcase
  endfunction
  initial forever begin
    @(posedge clk);
    for (int d = 0; d < 2; d++) begin
      if (!reset) begin
        mt[d] = -1;
        ms[d] = 0;
      end else begin
        if (mt[d] >= 1 && (mt[d] - 1) % 3 == 1) ms[d] = sign;
        if (mt[d] < 0) mt[d] = start ? 0 : -1;
        else if (mt[d] == 3 * pp[d] + 1) mt[d] = -1;
        else mt[d] = mt[d] + 1;
      end
      q[d].push_back(mexp(mt[d], pp[d], ms[d]));
    end
  end
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (q[d].size() > 0) check(d == 0 ? "outs_p4" : "outs_p1", 32'(o[d]), 32'(q[d].pop_front()));
      if (o[d][8]) begin
        rc[d] = 0; na[d] = 0; nb[d] = 0; nw[d] = 0;
      end else rc[d] = rc[d] + 1;
      na[d] = na[d] + int'(o[d][7]);
      nb[d] = nb[d] + int'(o[d][5]);
      nw[d] = nw[d] + int'(o[d][2]);
      if (o[d][0]) begin
        check("run_len", 32'(rc[d]), 32'(3 * pp[d] + 1));
        check("incA_cnt", 32'(na[d]), 32'(2 * pp[d]));
        check("incB_cnt", 32'(nb[d]), 32'(pp[d]));
        check("we_b_cnt", 32'(nw[d]), 32'(pp[d]));
      end
    end
  end
  task automatic step(input bit r, input bit s, input bit sg);
    reset = r; start = s; sign = sg;
    @(posedge clk);
    #2;
  endtask
  initial begin
    logic [3:0] pat;
    pat = 4'b1101;
    repeat (3) step(0, 1, 1);
    repeat (2) step(1, 0, 0);
    check("idle_busy", 32'(bs4), 32'(0));
    check("idle_sel", 32'(sl4), 32'(0));
    step(1, 1, 1'($urandom));
    for (int c = 1; c <= 20; c++)
      step(1, c == 5 || c == 14, (c % 3 == 0 && c <= 12) ? pat[3 - (c - 3) / 3] : 1'($urandom));
    step(1, 1, 0);
    for (int c = 1; c <= 6; c++) step(1, 0, 1'($urandom));
    step(0, 1, 1);
    check("abort_busy", 32'(bs4), 32'(0));
    check("abort_done", 32'(dn4), 32'(0));
    repeat (3) step(1, 0, 1'($urandom));
    check("no_restart", 32'(bs4), 32'(0));
    step(1, 1, 1'($urandom));
    for (int c = 1; c <= 18; c++) step(1, 0, 1'($urandom));
    for (int c = 0; c < 40; c++) step(1, 1, 1'($urandom));
    for (int c = 0; c < 20; c++) step(1, 0, 1'($urandom));
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
